// File: rtl/lane_read_gate_trainer_if.sv
// Lane-controller side of the read-gate trainer.
// Carries clock select, clock pause, probe read, delay-line control and the two status returns.
interface lane_read_gate_trainer_if;
   logic [2:0] READ_CLK_SEL;
   logic       HS_IO_CLK_PAUSE;
   logic       DDR_READ;
   logic       DELAY_LINE_SEL;
   logic       DELAY_LINE_LOAD;
   logic       DELAY_LINE_DIRECTION;
   logic       DELAY_LINE_MOVE;
   logic       RX_BURST_DETECT;
   logic       RX_DELAY_LINE_OUT_OF_RANGE;

   modport master (
      output READ_CLK_SEL, HS_IO_CLK_PAUSE, DDR_READ, DELAY_LINE_SEL,
             DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
      input  RX_BURST_DETECT, RX_DELAY_LINE_OUT_OF_RANGE
   );

   modport slave (
      input  READ_CLK_SEL, HS_IO_CLK_PAUSE, DDR_READ, DELAY_LINE_SEL,
             DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
      output RX_BURST_DETECT, RX_DELAY_LINE_OUT_OF_RANGE
   );
endinterface

// File: rtl/lane_read_gate_trainer.sv
// Read-gate trainer: probes all eight read-clock selects, centres on the widest passing run,
// then walks the fine delay line forward until bursts are lost and backs off to the middle.
module lane_read_gate_trainer #(
   parameter int PAUSE_CYCLES = 4,
   parameter int WAIT_CYCLES  = 16,
   parameter int MAX_TAPS     = 64
) (
   input  logic       FAB_CLK,
   input  logic       RESET,
   input  logic       START,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAIL,
   output logic [7:0] PASS_MAP,
   output logic [7:0] TAP_COUNT,
   lane_read_gate_trainer_if.master lane
);
   typedef enum logic [3:0] {
      IDLE, LOAD, PAUSE, PROBE_RD, PROBE_WAIT, EVAL, PICK, FINE_MOVE, BACK_MOVE, FINISH
   } state_t;

   localparam logic [7:0]  MAX_TAPS_W = 8'(MAX_TAPS);
   localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_CYCLES - 1);
   localparam logic [15:0] WAIT_LAST  = 16'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  sel_idx_q, sel_idx_d;
   logic [2:0]  rd_sel_q, rd_sel_d;
   logic [7:0]  pass_map_q, pass_map_d;
   logic [7:0]  tap_q, tap_d;
   logic [7:0]  back_q, back_d;
   logic [15:0] cnt_q, cnt_d;
   logic        fail_q, fail_d;
   logic        fine_q, fine_d;
   logic        hit_q, hit_d;
   logic        oor_q, oor_d;
   logic        gap_q, gap_d;
   logic        step_bad;
   logic        pause_c, read_c, load_c, move_c, dl_sel_c, dir_c, done_c;

   function automatic logic [7:0] tap_inc(input logic [7:0] t);
      if (t >= MAX_TAPS_W) return MAX_TAPS_W;
      return t + 8'd1;
   endfunction

   // Centre of the longest run of passing selects; earlier run wins a tie, no wrap 7->0.
   function automatic logic [2:0] pick_center(input logic [7:0] map);
      int run_len, run_st, best_len, best_st;
      run_len  = 0;
      run_st   = 0;
      best_len = 0;
      best_st  = 0;
      for (int i = 0; i < 8; i++) begin
         if (map[i]) begin
            if (run_len == 0) run_st = i;
            run_len++;
            if (run_len > best_len) begin
               best_len = run_len;
               best_st  = run_st;
            end
         end else begin
            run_len = 0;
         end
      end
      return 3'(best_st + (best_len - 1) / 2);
   endfunction

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         sel_idx_q  <= '0;
         rd_sel_q   <= '0;
         pass_map_q <= '0;
         tap_q      <= '0;
         back_q     <= '0;
         cnt_q      <= '0;
         fail_q     <= 1'b0;
         fine_q     <= 1'b0;
         hit_q      <= 1'b0;
         oor_q      <= 1'b0;
         gap_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_idx_q  <= sel_idx_d;
         rd_sel_q   <= rd_sel_d;
         pass_map_q <= pass_map_d;
         tap_q      <= tap_d;
         back_q     <= back_d;
         cnt_q      <= cnt_d;
         fail_q     <= fail_d;
         fine_q     <= fine_d;
         hit_q      <= hit_d;
         oor_q      <= oor_d;
         gap_q      <= gap_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_idx_d  = sel_idx_q;
      rd_sel_d   = rd_sel_q;
      pass_map_d = pass_map_q;
      tap_d      = tap_q;
      back_d     = back_q;
      cnt_d      = cnt_q;
      fail_d     = fail_q;
      fine_d     = fine_q;
      hit_d      = hit_q;
      oor_d      = oor_q;
      gap_d      = gap_q;
      pause_c    = 1'b0;
      read_c     = 1'b0;
      load_c     = 1'b0;
      move_c     = 1'b0;
      dl_sel_c   = 1'b0;
      dir_c      = 1'b0;
      done_c     = 1'b0;
      step_bad   = !hit_q || oor_q || lane.RX_DELAY_LINE_OUT_OF_RANGE;

      case (state_q)
         IDLE: begin
            if (START) begin
               pass_map_d = '0;
               tap_d      = '0;
               fail_d     = 1'b0;
               fine_d     = 1'b0;
               sel_idx_d  = '0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            load_c   = 1'b1;
            dl_sel_c = 1'b1;
            rd_sel_d = sel_idx_q;
            cnt_d    = '0;
            state_d  = PAUSE;
         end
         PAUSE: begin
            pause_c = 1'b1;
            if (cnt_q == PAUSE_LAST) begin
               cnt_d = '0;
               // A failed search also parks the clock on select 0 through a pause window.
               if (fail_q)      state_d = FINISH;
               else if (fine_q) state_d = FINE_MOVE;
               else             state_d = PROBE_RD;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         PROBE_RD: begin
            read_c  = 1'b1;
            hit_d   = 1'b0;
            oor_d   = oor_q | lane.RX_DELAY_LINE_OUT_OF_RANGE;
            cnt_d   = '0;
            state_d = PROBE_WAIT;
         end
         PROBE_WAIT: begin
            hit_d = hit_q | lane.RX_BURST_DETECT;
            oor_d = oor_q | lane.RX_DELAY_LINE_OUT_OF_RANGE;
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = EVAL;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         EVAL: begin
            if (!fine_q) begin
               pass_map_d[sel_idx_q] = hit_q;
               if (sel_idx_q != 3'd7) begin
                  sel_idx_d = sel_idx_q + 3'd1;
                  rd_sel_d  = sel_idx_q + 3'd1;
                  state_d   = PAUSE;
               end else begin
                  state_d = PICK;
               end
            end else if (!step_bad && (tap_q < MAX_TAPS_W)) begin
               state_d = FINE_MOVE;
            end else begin
               // A failed step leaves the line one tap past the last good one, hence the extra pulse.
               tap_d   = step_bad ? tap_q - 8'd1 : tap_q;
               back_d  = step_bad ? ((tap_q - 8'd1) >> 1) + 8'd1 : (tap_q >> 1);
               gap_d   = 1'b0;
               state_d = BACK_MOVE;
            end
         end
         PICK: begin
            if (pass_map_q == 8'd0) begin
               fail_d   = 1'b1;
               rd_sel_d = 3'd0;
            end else begin
               rd_sel_d = pick_center(pass_map_q);
               fine_d   = 1'b1;
            end
            cnt_d   = '0;
            state_d = PAUSE;
         end
         FINE_MOVE: begin
            dl_sel_c = 1'b1;
            dir_c    = 1'b1;
            move_c   = 1'b1;
            tap_d    = tap_inc(tap_q);
            oor_d    = lane.RX_DELAY_LINE_OUT_OF_RANGE;
            state_d  = PROBE_RD;
         end
         BACK_MOVE: begin
            dl_sel_c = 1'b1;
            if (back_q == 8'd0) begin
               state_d = FINISH;
            end else if (!gap_q) begin
               move_c = 1'b1;
               back_d = back_q - 8'd1;
               gap_d  = 1'b1;
            end else begin
               gap_d = 1'b0;
            end
         end
         FINISH: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign BUSY      = (state_q != IDLE) && (state_q != FINISH);
   assign DONE      = done_c;
   assign FAIL      = fail_q;
   assign PASS_MAP  = pass_map_q;
   assign TAP_COUNT = tap_q;

   assign lane.READ_CLK_SEL         = rd_sel_q;
   assign lane.HS_IO_CLK_PAUSE      = pause_c;
   assign lane.DDR_READ             = read_c;
   assign lane.DELAY_LINE_SEL       = dl_sel_c;
   assign lane.DELAY_LINE_LOAD      = load_c;
   assign lane.DELAY_LINE_DIRECTION = dir_c;
   assign lane.DELAY_LINE_MOVE      = move_c;
endmodule

// File: tb/tb_lane_read_gate_trainer.sv
// Scoreboard bench for lane_read_gate_trainer: a lane model answers probes from a simple eye
// description, expected results come from the training rules, a monitor checks each DONE.
module tb_lane_read_gate_trainer;
   localparam int PAUSE_CYCLES = 4;
   localparam int WAIT_CYCLES  = 16;
   localparam int MAX_TAPS     = 12;

   logic       FAB_CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic       BUSY, DONE, FAIL;
   logic [7:0] PASS_MAP, TAP_COUNT;

   lane_read_gate_trainer_if lane();

   lane_read_gate_trainer #(
      .PAUSE_CYCLES(PAUSE_CYCLES),
      .WAIT_CYCLES (WAIT_CYCLES),
      .MAX_TAPS    (MAX_TAPS)
   ) dut (
      .FAB_CLK  (FAB_CLK),
      .RESET    (RESET),
      .START    (START),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .FAIL     (FAIL),
      .PASS_MAP (PASS_MAP),
      .TAP_COUNT(TAP_COUNT),
      .lane     (lane)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   typedef struct {
      logic [7:0] map;
      int         tap;
      int         sel;
      int         fail;
      int         back;
      int         fwd;
      int         probes;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   exp_t mon_e;
   bit   have_last = 1'b0;

   int checks = 0;
   int passes = 0;

   // Eye description used by the lane model for the current run.
   logic [7:0] sc_pass = 8'h00;
   int         sc_good = 0;
   int         sc_oor  = 0;
   bit         sc_noise = 1'b0;

   int done_seen = 0;
   int n_rd = 0, n_fwd = 0, n_back = 0;
   int proto_excl = 0, proto_pause = 0, proto_sel = 0, proto_done = 0;
   int pause_windows = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act == exp_v) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask

   // Expected training outcome straight from the rules: widest run centre, then count fine steps.
   function automatic exp_t model(input logic [7:0] ps, input int g, input int o);
      exp_t e;
      int best_len, best_st, len, fk;
      e.map = ps; e.tap = 0; e.back = 0; e.fwd = 0; e.probes = 8;
      if (ps == 8'h00) begin
         e.fail = 1; e.sel = 0;
         return e;
      end
      e.fail = 0;
      best_len = 0; best_st = 0;
      for (int st = 0; st < 8; st++) begin
         len = 0;
         while (st + len < 8 && ps[st + len]) len++;
         if (len > best_len) begin best_len = len; best_st = st; end
      end
      e.sel = best_st + (best_len - 1) / 2;
      fk = g + 1;
      if (o > 0 && o < fk) fk = o;
      if (fk <= MAX_TAPS) begin
         e.fwd = fk; e.tap = fk - 1; e.back = (fk - 1) / 2 + 1;
      end else begin
         e.fwd = MAX_TAPS; e.tap = MAX_TAPS; e.back = MAX_TAPS / 2;
      end
      e.probes = 8 + e.fwd;
      return e;
   endfunction

   // Lane model: delay position tracks LOAD/MOVE; a probe hits when the select passes and
   // the position is within the good taps; burst arrives 1..WAIT_CYCLES cycles later.
   initial begin
      int pos, cd;
      bit burst;
      pos = 0; cd = 0;
      lane.RX_BURST_DETECT = 1'b0;
      lane.RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
      forever begin
         @(posedge FAB_CLK); #2;
         burst = 1'b0;
         if (cd > 0) begin cd--; burst = (cd == 0); end
         if (lane.DELAY_LINE_LOAD) pos = 0;
         if (lane.DELAY_LINE_MOVE) pos = lane.DELAY_LINE_DIRECTION ? pos + 1 : pos - 1;
         if (lane.DDR_READ && sc_pass[lane.READ_CLK_SEL] && pos <= sc_good)
            cd = $urandom_range(WAIT_CYCLES, 1);
         if (sc_noise && lane.HS_IO_CLK_PAUSE && cd == 0 && !burst)
            burst = ($urandom_range(3, 0) == 0);
         if (RESET) begin cd = 0; burst = 1'b0; end
         lane.RX_BURST_DETECT = burst;
         lane.RX_DELAY_LINE_OUT_OF_RANGE = (sc_oor > 0 && pos == sc_oor);
      end
   end

   // Monitor: scoreboard pop on DONE plus per-cycle protocol observation.
   initial begin
      int plen, excl;
      logic [2:0] sel_prev;
      bit rst_prev, done_prev;
      plen = 0; sel_prev = 3'd0; rst_prev = 1'b1; done_prev = 1'b0;
      forever begin
         @(negedge FAB_CLK);
         if (RESET) begin
            n_rd = 0; n_fwd = 0; n_back = 0;
         end else begin
            if (lane.DDR_READ) n_rd++;
            if (lane.DELAY_LINE_MOVE) begin
               if (lane.DELAY_LINE_DIRECTION) n_fwd++;
               else n_back++;
            end
            if (DONE) begin
               done_seen++;
               if (sb_q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  mon_e = sb_q.pop_front();
                  chk("pass_map",  int'(PASS_MAP), int'(mon_e.map));
                  chk("tap_count", int'(TAP_COUNT), mon_e.tap);
                  chk("read_sel",  int'(lane.READ_CLK_SEL), mon_e.sel);
                  chk("fail",      int'(FAIL), mon_e.fail);
                  chk("back_pulses", n_back, mon_e.back);
                  chk("fwd_pulses",  n_fwd, mon_e.fwd);
                  chk("probes",      n_rd, mon_e.probes);
                  chk("busy_at_done", int'(BUSY), 0);
                  last_exp = mon_e;
                  have_last = 1'b1;
               end
               n_rd = 0; n_fwd = 0; n_back = 0;
            end
         end
         excl = int'(lane.DDR_READ) + int'(lane.DELAY_LINE_MOVE) +
                int'(lane.DELAY_LINE_LOAD) + int'(lane.HS_IO_CLK_PAUSE);
         if (excl > 1) proto_excl++;
         if (done_prev && DONE) proto_done++;
         if (RESET) plen = 0;
         else if (lane.HS_IO_CLK_PAUSE) plen++;
         else begin
            if (plen != 0) begin
               pause_windows++;
               if (plen != PAUSE_CYCLES) proto_pause++;
            end
            plen = 0;
         end
         if (!rst_prev && lane.READ_CLK_SEL != sel_prev && !lane.HS_IO_CLK_PAUSE) proto_sel++;
         sel_prev  = lane.READ_CLK_SEL;
         rst_prev  = RESET;
         done_prev = DONE;
      end
   end

   task automatic step();
      @(posedge FAB_CLK); #1;
   endtask

   task automatic run(input logic [7:0] ps, input int g, input int o, input bit poke);
      exp_t e;
      int start_done, n;
      if (have_last) begin
         chk("hold_map",  int'(PASS_MAP), int'(last_exp.map));
         chk("hold_tap",  int'(TAP_COUNT), last_exp.tap);
         chk("hold_sel",  int'(lane.READ_CLK_SEL), last_exp.sel);
         chk("hold_fail", int'(FAIL), last_exp.fail);
      end
      sc_pass = ps; sc_good = g; sc_oor = o;
      sc_noise = ($urandom_range(1, 0) == 1);
      e = model(ps, g, o);
      sb_q.push_back(e);
      start_done = done_seen;
      START = 1'b1;
      step();
      START = 1'b0;
      chk("busy_after_start", int'(BUSY), 1);
      n = 0;
      while (done_seen == start_done && n < 3000) begin
         START = (poke && BUSY && $urandom_range(40, 0) == 0);
         step();
         n++;
      end
      START = 1'b0;
      if (done_seen == start_done) begin
         chk("done_timeout", 0, 1);
         sb_q.delete();
      end
      repeat ($urandom_range(4, 1)) step();
   endtask

   task automatic reset_mid_training();
      int n, k;
      sc_pass = 8'h3C; sc_good = 10; sc_oor = 0; sc_noise = 1'b0;
      START = 1'b1;
      step();
      START = 1'b0;
      n = 0; k = 0;
      while (k < 4 && n < 500) begin
         if (lane.DDR_READ) k++;
         step();
         n++;
      end
      chk("reached_probe4", k, 4);
      repeat (3) step();
      chk("pre_reset_map", int'(PASS_MAP), 4);
      chk("pre_reset_sel", int'(lane.READ_CLK_SEL), 3);
      RESET = 1'b1;
      START = 1'b1;
      step();
      RESET = 1'b0;
      START = 1'b0;
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_done", int'(DONE), 0);
      chk("rst_fail", int'(FAIL), 0);
      chk("rst_map",  int'(PASS_MAP), 0);
      chk("rst_tap",  int'(TAP_COUNT), 0);
      chk("rst_sel",  int'(lane.READ_CLK_SEL), 0);
      chk("rst_lane_ctl", int'({lane.HS_IO_CLK_PAUSE, lane.DDR_READ, lane.DELAY_LINE_SEL,
                                lane.DELAY_LINE_LOAD, lane.DELAY_LINE_DIRECTION,
                                lane.DELAY_LINE_MOVE}), 0);
      step();
      chk("start_with_reset_ignored", int'(BUSY), 0);
      have_last = 1'b0;
   endtask

   initial begin
      logic [7:0] ps;
      int g, o;
      RESET = 1'b1;
      START = 1'b0;
      repeat (3) step();
      chk("init_busy", int'(BUSY), 0);
      chk("init_outputs", int'({DONE, FAIL, PASS_MAP, TAP_COUNT, lane.READ_CLK_SEL}), 0);
      RESET = 1'b0;
      step();

      run(8'h3C, 10, 0, 1'b0);
      run(8'h00, 0, 0, 1'b0);
      run(8'hE3, 4, 0, 1'b1);
      run(8'h18, 255, 0, 1'b0);
      run(8'h18, 255, 3, 1'b0);
      run(8'h33, 5, 0, 1'b1);
      run(8'h81, 0, 0, 1'b0);
      run(8'h80, 7, 0, 1'b0);

      reset_mid_training();
      run(8'h3C, 10, 0, 1'b1);

      for (int r = 0; r < 20; r++) begin
         ps = ($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
         g  = $urandom_range(15, 0);
         o  = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(14, 1);
         run(ps, g, o, ($urandom_range(1, 0) == 1));
      end

      repeat (5) step();
      chk("scoreboard_empty", sb_q.size(), 0);
      chk("proto_exclusive", proto_excl, 0);
      chk("proto_pause_len", proto_pause, 0);
      chk("proto_sel_change", proto_sel, 0);
      chk("proto_done_pulse", proto_done, 0);
      chk("pause_windows_seen", int'(pause_windows > 0), 1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
      $fatal(1);
   end
endmodule
